// File: rtl/kyogenrv_pio_pkg.sv
// Shared constants for the KyogenRV PIO blocks: register addresses, edge modes
// and pipeline depth (KYOGENRV_PIO_IN_SYNC_EN selects the two-flop synchronizer).
package kyogenrv_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

`ifdef KYOGENRV_PIO_IN_SYNC_EN
  localparam int PIO_IN_DEPTH = 3;
`else
  localparam int PIO_IN_DEPTH = 2;
`endif

endpackage

// File: rtl/kyogenrv_fpga_pio_in_if.sv
// Avalon-MM slave bus bundle for the PIO input port.
// Handshake: a write is accepted on every clk edge where chipselect && !write_n;
// reads need no strobe, readdata follows address one cycle later, no waitrequest.
interface kyogenrv_fpga_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/kyogenrv_pio_edge_det.sv
// Input sampling pipeline, arming counter and per-bit edge function.
// KYOGENRV_PIO_IN_SYNC_EN adds a metastability flop in front of sync_q.
module kyogenrv_pio_edge_det
  import kyogenrv_pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = PIO_EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_in_port,
  output logic [WIDTH-1:0] o_sync_q,
  output logic [WIDTH-1:0] o_edge
);

  localparam logic [1:0] DEPTH = 2'(PIO_IN_DEPTH);

  logic [WIDTH-1:0] r_sync_q;
  logic [WIDTH-1:0] r_prev_q;
  logic [WIDTH-1:0] w_edge_raw;
  logic [1:0]       r_fill_cnt;
  logic             w_armed;

`ifdef KYOGENRV_PIO_IN_SYNC_EN
  logic [WIDTH-1:0] r_meta_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta_q <= '0;
      r_sync_q <= '0;
    end else begin
      r_meta_q <= i_in_port;
      r_sync_q <= r_meta_q;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync_q <= '0;
    else       r_sync_q <= i_in_port;
  end
`endif

  // Edges stay gated until every stage holds a real post-reset sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_q   <= '0;
      r_fill_cnt <= '0;
    end else begin
      r_prev_q <= r_sync_q;
      if (r_fill_cnt != DEPTH) r_fill_cnt <= r_fill_cnt + 2'd1;
    end
  end

  assign w_armed = (r_fill_cnt == DEPTH);

  always_comb begin
    w_edge_raw = r_sync_q & ~r_prev_q;
    if (EDGE_TYPE == PIO_EDGE_FALL)     w_edge_raw = ~r_sync_q & r_prev_q;
    else if (EDGE_TYPE == PIO_EDGE_ANY) w_edge_raw = r_sync_q ^ r_prev_q;
  end

  assign o_sync_q = r_sync_q;
  assign o_edge   = w_armed ? w_edge_raw : '0;

endmodule

// File: rtl/kyogenrv_fpga_pio_in.sv
// Avalon-MM input PIO: data, irqmask and sticky edgecapture registers plus level irq.
// Latencies depend on KYOGENRV_PIO_IN_SYNC_EN (see kyogenrv_pio_edge_det).
module kyogenrv_fpga_pio_in
  import kyogenrv_pio_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          EDGE_TYPE  = PIO_EDGE_RISE,
  parameter logic [31:0] RESET_MASK = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  kyogenrv_fpga_pio_in_if.slave  bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      w_rd_data;
  logic [31:0]      r_readdata;
  logic             r_irq;
  logic             w_wr;

  kyogenrv_pio_edge_det #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_det (
    .clk       (clk),
    .reset     (reset),
    .i_in_port (in_port),
    .o_sync_q  (w_sync_q),
    .o_edge    (w_edge)
  );

  assign w_wr  = bus.chipselect && !bus.write_n;
  assign w_clr = (w_wr && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  // A fresh edge wins over a write-1-to-clear landing on the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqmask <= RESET_MASK[WIDTH-1:0];
      r_edgecap <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && bus.address == PIO_ADDR_IRQMASK) r_irqmask <= bus.writedata[WIDTH-1:0];
      r_edgecap <= w_edge | (r_edgecap & ~w_clr);
      r_irq     <= |(r_edgecap & r_irqmask);
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (bus.address)
      PIO_ADDR_DATA:    w_rd_data[WIDTH-1:0] = w_sync_q;
      PIO_ADDR_IRQMASK: w_rd_data[WIDTH-1:0] = r_irqmask;
      PIO_ADDR_EDGECAP: w_rd_data[WIDTH-1:0] = r_edgecap;
      default:          w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rd_data;
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_kyogenrv_fpga_pio_in.sv
// Bench for kyogenrv_fpga_pio_in: rise/fall/any instances on a shared stimulus,
// checked each cycle against a sample-history reference model.
module tb_kyogenrv_fpga_pio_in;

`ifdef KYOGENRV_PIO_IN_SYNC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  localparam int          TYP [3] = '{0, 1, 2};
  localparam logic [31:0] WM  [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};
  localparam logic [31:0] RM  [3] = '{32'h0000_0000, 32'h0000_00C3, 32'h8000_0001};

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] in_port = 32'hFFFF_FFFF;
  logic [1:0]  address = 2'd0;
  logic        cs = 1'b0;
  logic        wr_n = 1'b1;
  logic [31:0] wdata = '0;

  kyogenrv_fpga_pio_in_if bus_r ();
  kyogenrv_fpga_pio_in_if bus_f ();
  kyogenrv_fpga_pio_in_if bus_a ();

  assign bus_r.address = address;  assign bus_r.chipselect = cs;
  assign bus_r.write_n = wr_n;     assign bus_r.writedata  = wdata;
  assign bus_f.address = address;  assign bus_f.chipselect = cs;
  assign bus_f.write_n = wr_n;     assign bus_f.writedata  = wdata;
  assign bus_a.address = address;  assign bus_a.chipselect = cs;
  assign bus_a.write_n = wr_n;     assign bus_a.writedata  = wdata;

  logic irq_r, irq_f, irq_a;

  kyogenrv_fpga_pio_in #(.WIDTH(32), .EDGE_TYPE(0), .RESET_MASK(32'h0000_0000)) u_rise (
    .clk(clk), .reset(reset), .bus(bus_r), .in_port(in_port), .irq(irq_r));
  kyogenrv_fpga_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .RESET_MASK(32'h0000_00C3)) u_fall (
    .clk(clk), .reset(reset), .bus(bus_f), .in_port(in_port[7:0]), .irq(irq_f));
  kyogenrv_fpga_pio_in #(.WIDTH(32), .EDGE_TYPE(2), .RESET_MASK(32'h8000_0001)) u_any (
    .clk(clk), .reset(reset), .bus(bus_a), .in_port(in_port), .irq(irq_a));

  logic [31:0] rd_d [3];
  logic        irq_d [3];
  assign rd_d[0] = bus_r.readdata;  assign irq_d[0] = irq_r;
  assign rd_d[1] = bus_f.readdata;  assign irq_d[1] = irq_f;
  assign rd_d[2] = bus_a.readdata;  assign irq_d[2] = irq_a;

  // reference model: history of in_port samples since reset; an edge is
  // visible once DEPTH real samples exist, between the two oldest still in flight
  logic [31:0] smp_q [$];
  logic [31:0] ec_m [3];
  logic [31:0] mask_m [3];
  logic [31:0] rd_m [3];
  logic        irq_m [3];
  logic [31:0] m_sync, m_prv, m_edg;
  logic        m_armed, m_wr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_q.delete();
      for (int i = 0; i < 3; i++) begin
        ec_m[i] = '0; mask_m[i] = RM[i] & WM[i]; rd_m[i] = '0; irq_m[i] = 1'b0;
      end
    end else begin
      m_sync  = (smp_q.size() >= DEPTH - 1) ? smp_q[smp_q.size() + 1 - DEPTH] : 32'h0;
      m_armed = (smp_q.size() >= DEPTH);
      m_prv   = m_armed ? smp_q[smp_q.size() - DEPTH] : 32'h0;
      m_wr    = cs && !wr_n;
      for (int i = 0; i < 3; i++) begin
        if (!m_armed)         m_edg = '0;
        else if (TYP[i] == 0) m_edg = m_sync & ~m_prv;
        else if (TYP[i] == 1) m_edg = ~m_sync & m_prv;
        else                  m_edg = m_sync ^ m_prv;
        m_edg = m_edg & WM[i];
        irq_m[i] = |(ec_m[i] & mask_m[i]);
        case (address)
          2'd0:    rd_m[i] = m_sync & WM[i];
          2'd2:    rd_m[i] = mask_m[i];
          2'd3:    rd_m[i] = ec_m[i];
          default: rd_m[i] = '0;
        endcase
        if (m_wr && address == 2'd3) ec_m[i] = m_edg | (ec_m[i] & ~(wdata & WM[i]));
        else                         ec_m[i] = m_edg | ec_m[i];
        if (m_wr && address == 2'd2) mask_m[i] = wdata & WM[i];
      end
      smp_q.push_back(in_port);
      if (smp_q.size() > DEPTH) void'(smp_q.pop_front());
    end
  end

  // scoreboard
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_rd%0d", i), rd_d[i], rd_m[i]);
      chk($sformatf("model_irq%0d", i), {31'b0, irq_d[i]}, {31'b0, irq_m[i]});
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; wdata = d; cs = 1'b1; wr_n = 1'b0;
    cyc(1);
    cs = 1'b0; wr_n = 1'b1;
  endtask

  initial begin
    // arming with a high input held through reset release
    repeat (3) @(negedge clk);
    chk("reset_rd", rd_d[0], 32'h0);
    chk("reset_irq", {31'b0, irq_r}, 32'h0);
    reset = 1'b0;
    address = 2'd3;
    cyc(6);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arm_ec%0d", i), rd_d[i], 32'h0);
      chk($sformatf("arm_irq%0d", i), {31'b0, irq_d[i]}, 32'h0);
    end

    // rising capture and interrupt
    bus_write(2'd2, 32'h0000_0001);
    in_port = 32'h0;
    cyc(DEPTH + 2);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h1;
    address = 2'd3;
    cyc(DEPTH + 2);
    chk("rise_ec", rd_d[0], 32'h1);
    chk("rise_irq", {31'b0, irq_r}, 32'h1);
    bus_write(2'd3, 32'h1);
    cyc(2);
    chk("rise_clr_irq", {31'b0, irq_r}, 32'h0);
    chk("rise_clr_ec", rd_d[0], 32'h0);

    // clear/set collision on bit 0
    in_port = 32'h0;
    cyc(DEPTH + 2);
    in_port = 32'h1;
    cyc(DEPTH - 1);
    bus_write(2'd3, 32'h1);
    address = 2'd3;
    cyc(2);
    chk("collide_ec", rd_d[0], 32'h1);

    // masked edge on bit 5 (any-edge instance)
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port[5] = 1'b1;
    cyc(4);
    in_port[5] = 1'b0;
    address = 2'd3;
    cyc(4);
    chk("mask_ec", rd_d[2], 32'h20);
    chk("mask_irq0", {31'b0, irq_a}, 32'h0);
    bus_write(2'd2, 32'h20);
    cyc(2);
    chk("mask_irq1", {31'b0, irq_a}, 32'h1);

    // data readback and reserved address
    in_port = 32'hA5A5_5AA5;
    cyc(DEPTH + 2);
    address = 2'd0;
    cyc(1);
    chk("data_rd32", rd_d[0], 32'hA5A5_5AA5);
    chk("data_rd8", rd_d[1], 32'h0000_00A5);
    address = 2'd1;
    cyc(1);
    chk("rsvd_rd", rd_d[2], 32'h0);
    bus_write(2'd0, 32'h1234_5678);
    address = 2'd0;
    cyc(1);
    chk("data_nowrite", rd_d[0], 32'hA5A5_5AA5);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) in_port = $urandom;
      else if ($urandom_range(0, 1) == 0) in_port = in_port ^ (32'h1 << $urandom_range(0, 31));
      address = 2'($urandom_range(0, 3));
      cs      = 1'($urandom_range(0, 1));
      wr_n    = 1'($urandom_range(0, 1));
      wdata   = $urandom;
      cyc(1);
    end
    cs = 1'b0; wr_n = 1'b1;

    // reset mid-operation with edgecapture = F and irq high
    bus_write(2'd2, 32'hF);
    in_port = 32'h0;
    cyc(DEPTH + 2);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'hF;
    cyc(DEPTH + 2);
    in_port = 32'h0;
    address = 2'd3;
    cyc(DEPTH + 2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pre_rst_ec%0d", i), rd_d[i], 32'hF);
      chk($sformatf("pre_rst_irq%0d", i), {31'b0, irq_d[i]}, 32'h1);
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst_rd%0d", i), rd_d[i], 32'h0);
      chk($sformatf("async_rst_irq%0d", i), {31'b0, irq_d[i]}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    address = 2'd2;
    cyc(1);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_mask%0d", i), rd_d[i], RM[i] & WM[i]);
    address = 2'd3;
    cyc(DEPTH + 3);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_ec%0d", i), rd_d[i], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
